// File: rtl/grid_line_clear.sv
// Line-clear engine: scans the playfield bottom-up, collapses full rows and zero-fills row 0.
// Latency: one grid cell per cycle in every state, plus one DONE cycle.
// Backpressure: none; start is accepted only in IDLE, and a start while busy is dropped.
module grid_line_clear #(
   parameter int ROWS    = 10,
   parameter int COLS    = 10,
   parameter int COLOR_W = 3,
   parameter int ROW_W   = 4,
   parameter int COL_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ROW_W-1:0]   lines_cleared,
   output logic [ROW_W-1:0]   rd_row,
   output logic [COL_W-1:0]   rd_col,
   input  logic [COLOR_W-1:0] rd_data,
   output logic               wr_en,
   output logic [ROW_W-1:0]   wr_row,
   output logic [COL_W-1:0]   wr_col,
   output logic [COLOR_W-1:0] wr_data
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SHIFT,
      CLEAR_TOP,
      DONE
   } state_t;

   state_t           state, state_nx;
   logic [ROW_W-1:0] r, r_nx;
   logic [ROW_W-1:0] rr, rr_nx;
   logic [COL_W-1:0] c, c_nx;
   logic [ROW_W-1:0] lines, lines_nx;

   assign lines_cleared = lines;

   // State and counter registers; reset abandons any partly shifted grid as-is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         r     <= '0;
         rr    <= '0;
         c     <= '0;
         lines <= '0;
      end else begin
         state <= state_nx;
         r     <= r_nx;
         rr    <= rr_nx;
         c     <= c_nx;
         lines <= lines_nx;
      end
   end

   // Next-state, counter updates and grid port drive, all from the current state.
   always_comb begin
      state_nx = state;
      r_nx     = r;
      rr_nx    = rr;
      c_nx     = c;
      lines_nx = lines;
      busy     = 1'b1;
      done     = 1'b0;
      rd_row   = '0;
      rd_col   = '0;
      wr_en    = 1'b0;
      wr_row   = '0;
      wr_col   = '0;
      wr_data  = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nx = SCAN;
               r_nx     = ROW_LAST;
               c_nx     = '0;
               lines_nx = '0;
            end
         end
         SCAN: begin
            rd_row = r;
            rd_col = c;
            if (rd_data == '0) begin
               // Any empty cell ends this row early; move up or finish at the top.
               if (r == '0) begin
                  state_nx = DONE;
               end else begin
                  r_nx = r - ROW_ONE;
                  c_nx = '0;
               end
            end else if (c != COL_LAST) begin
               c_nx = c + 1'b1;
            end else begin
               lines_nx = lines + 1'b1;
               c_nx     = '0;
               if (r == '0) begin
                  state_nx = CLEAR_TOP;
               end else begin
                  state_nx = SHIFT;
                  rr_nx    = r;
               end
            end
         end
         SHIFT: begin
            // Copy row rr-1 into row rr through the combinational read port.
            rd_row  = rr - ROW_ONE;
            rd_col  = c;
            wr_en   = 1'b1;
            wr_row  = rr;
            wr_col  = c;
            wr_data = rd_data;
            if (c != COL_LAST) begin
               c_nx = c + 1'b1;
            end else begin
               c_nx = '0;
               if (rr == ROW_ONE) state_nx = CLEAR_TOP;
               else               rr_nx    = rr - ROW_ONE;
            end
         end
         CLEAR_TOP: begin
            wr_en  = 1'b1;
            wr_col = c;
            if (c != COL_LAST) begin
               c_nx = c + 1'b1;
            end else begin
               // Same r: the row just shifted into it may itself be full.
               c_nx     = '0;
               state_nx = SCAN;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_grid_line_clear.sv
// Directed bench for grid_line_clear with a behavioural grid memory.
// Pass timing is counted from the cycle start is presented (cycle 0).
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_grid_line_clear;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] lines_cleared;
   logic [3:0] rd_row;
   logic [3:0] rd_col;
   logic [2:0] rd_data;
   logic       wr_en;
   logic [3:0] wr_row;
   logic [3:0] wr_col;
   logic [2:0] wr_data;

   logic [2:0] grid [10][10];
   logic [2:0] pat  [10][10];
   logic       load_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   grid_line_clear dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .rd_row        (rd_row),
      .rd_col        (rd_col),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_row        (wr_row),
      .wr_col        (wr_col),
      .wr_data       (wr_data)
   );

   // Grid store: combinational read, write on posedge; bulk load from pat.
   always_comb begin
      rd_data = '0;
      if (rd_row < 4'd10 && rd_col < 4'd10) rd_data = grid[rd_row][rd_col];
   end

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
               grid[i][j] <= pat[i][j];
      end else if (wr_en && wr_row < 4'd10 && wr_col < 4'd10) begin
         grid[wr_row][wr_col] <= wr_data;
      end
   end

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 10; j++)
            pat[i][j] = 3'd0;
   endtask

   task automatic load_grid();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   function automatic int nonzero_cells();
      int n = 0;
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 10; j++)
            if (grid[i][j] != 3'd0) n++;
      return n;
   endfunction

   // One start pulse at cycle 0; optional extra start pulses at cycles re1/re2.
   task automatic run_pass(input int re1, input int re2, output int cyc,
                           output int nwr, output int ndone, output int nr9);
      cyc = -1; nwr = 0; ndone = 0; nr9 = 0;
      start = 1'b1;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (wr_en) nwr++;
         if (done) begin
            ndone++;
            if (cyc < 0) cyc = k;
         end
         if (busy && !wr_en && !done && rd_row == 4'd9) nr9++;
         start = (k == re1 || k == re2);
         if (cyc >= 0 && k >= cyc + 3) break;
      end
      start = 1'b0;
      if (cyc < 0) check("pass_timeout", 0, 1);
   endtask

   int cyc, nwr, ndone, nr9;

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      load_req = 1'b0;
      clear_pat();
      repeat (2) @(negedge clk);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_lines", lines_cleared, 0);
      check("rst_rd_row", rd_row, 0);
      check("rst_rd_col", rd_col, 0);
      reset = 1'b0;
      load_grid();

      // Empty grid: one scan cycle per row.
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("empty_cycles", cyc, 11);
      check("empty_lines", lines_cleared, 0);
      check("empty_writes", nwr, 0);
      check("empty_done_pulses", ndone, 1);

      // Bottom row full.
      clear_pat();
      for (int j = 0; j < 10; j++) pat[9][j] = 3'b001;
      load_grid();
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("row9_cycles", cyc, 121);
      check("row9_lines", lines_cleared, 1);
      check("row9_writes", nwr, 100);
      check("row9_grid_empty", nonzero_cells(), 0);

      // Two full rows with a lone cell above them.
      clear_pat();
      for (int j = 0; j < 10; j++) begin
         pat[8][j] = 3'b011;
         pat[9][j] = 3'b101;
      end
      pat[7][0] = 3'b010;
      load_grid();
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("two_cycles", cyc, 232);
      check("two_lines", lines_cleared, 2);
      check("two_cell_9_0", grid[9][0], 2);
      check("two_nonzero", nonzero_cells(), 1);

      // Bottom row with a hole in the last column.
      clear_pat();
      for (int j = 0; j < 9; j++) pat[9][j] = 3'b111;
      load_grid();
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("hole_cycles", cyc, 20);
      check("hole_lines", lines_cleared, 0);
      check("hole_writes", nwr, 0);
      check("hole_row9_scan", nr9, 10);

      // Reset in the middle of a shift, then a fresh pass.
      clear_pat();
      for (int j = 0; j < 10; j++) pat[9][j] = 3'b001;
      load_grid();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("mid_shift_wr_en", wr_en, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_wr_en", wr_en, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("after_rst_cycles", cyc, 11);
      check("after_rst_lines", lines_cleared, 0);
      check("after_rst_writes", nwr, 0);

      // Start pulses while busy are ignored.
      clear_pat();
      for (int j = 0; j < 10; j++) pat[9][j] = 3'b001;
      load_grid();
      run_pass(5, 50, cyc, nwr, ndone, nr9);
      check("restart_cycles", cyc, 121);
      check("restart_done_pulses", ndone, 1);
      check("restart_lines", lines_cleared, 1);

      // Every cell occupied: ten clears, nothing left.
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 10; j++)
            pat[i][j] = 3'((i + j) % 7 + 1);
      load_grid();
      run_pass(0, 0, cyc, nwr, ndone, nr9);
      check("full_cycles", cyc, 1111);
      check("full_lines", lines_cleared, 10);
      check("full_writes", nwr, 1000);
      check("full_grid_empty", nonzero_cells(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
